// File: rtl/mat_result_drain.sv
// -----------------------------------------------------------------------------
// mat_result_drain
//
// Reader-side buffer for the FPU matrix wrapper's result interface. A single
// cycle in_valid pulse delivers the four words of a 2x2 product. The block
// stores up to DEPTH such matrices. It streams them out one word per cycle in
// row-major order (r00, r01, r10, r11) over a valid/ready handshake.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-low reset
//   in_valid   single-cycle pulse; in_r00..in_r11 are valid this cycle
//   in_r00..11 result elements (row/col)
//   in_ready   advisory: at least one slot free (registered with count)
//   out_valid  out_data holds a valid word
//   out_data   current result word (0 while out_valid is low)
//   out_idx    element index 0..3 (r00, r01, r10, r11)
//   out_last   high with out_idx == 3
//   out_ready  sink accepts the word this cycle
//   count      occupied slots, 0..DEPTH
//   overflow   sticky: a matrix arrived while full and was dropped
// -----------------------------------------------------------------------------
module mat_result_drain #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 2,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_r00,
  input  logic [DATA_W-1:0] in_r01,
  input  logic [DATA_W-1:0] in_r10,
  input  logic [DATA_W-1:0] in_r11,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_idx,
  output logic              out_last,
  input  logic              out_ready,
  output logic [CW-1:0]     count,
  output logic              overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } state_t;

  logic [DATA_W-1:0] r_mem [DEPTH][4];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [1:0]        r_idx;
  state_t            r_state;
  logic              r_out_valid;
  logic              r_out_last;
  logic              r_in_ready;
  logic              r_overflow;

  logic              w_full;
  logic              w_wr_en;
  logic              w_hs;
  logic              w_free;
  logic [CW-1:0]     w_count_nxt;

  // Fullness is judged on the pre-edge count: a slot freed on this same edge
  // does not admit the incoming matrix.
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_wr_en     = in_valid & ~w_full;
  assign w_hs        = r_out_valid & out_ready;
  assign w_free      = w_hs & (r_idx == 2'd3);
  assign w_count_nxt = r_count + CW'(w_wr_en) - CW'(w_free);

  // NOTE: storage has no reset; stale slot contents are never visible because
  // out_data is gated by out_valid and a slot is only read after being written.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr][0] <= in_r00;
      r_mem[r_wr_ptr][1] <= in_r01;
      r_mem[r_wr_ptr][2] <= in_r10;
      r_mem[r_wr_ptr][3] <= in_r11;
    end
  end

  // Write side and occupancy. Pointers wrap naturally since DEPTH is a power
  // of two. A capture and a slot-free on the same edge leave count unchanged.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt < CW'(DEPTH));
      if (in_valid && w_full) r_overflow <= 1'b1;
    end
  end

  // Read FSM. Decisions use the post-edge count, so a matrix captured on
  // edge T is presented from the cycle right after T, and back-to-back
  // matrices stream without a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_idx       <= 2'd0;
      r_rd_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_count_nxt != '0) begin
            r_state     <= S_STREAM;
            r_idx       <= 2'd0;
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
          end
        end
        S_STREAM: begin
          if (w_hs) begin
            if (r_idx == 2'd3) begin
              r_idx      <= 2'd0;
              r_out_last <= 1'b0;
              r_rd_ptr   <= r_rd_ptr + AW'(1);
              if (w_count_nxt == '0) begin
                r_state     <= S_IDLE;
                r_out_valid <= 1'b0;
              end
            end else begin
              r_idx      <= r_idx + 2'd1;
              r_out_last <= (r_idx == 2'd2);
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
        end
      endcase
    end
  end

  assign out_data  = r_out_valid ? r_mem[r_rd_ptr][r_idx] : '0;
  assign out_valid = r_out_valid;
  assign out_idx   = r_idx;
  assign out_last  = r_out_last;
  assign count     = r_count;
  assign in_ready  = r_in_ready;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_mat_result_drain.sv
// -----------------------------------------------------------------------------
// tb_mat_result_drain
//
// Scoreboard bench. The driver decides whether each matrix is admitted. It
// bases that on the number of matrices held before the capturing edge
// (admitted minus fully drained). It pushes the four expected words for an
// admitted matrix. A monitor on the falling edge compares the presented word,
// count, in_ready and overflow. It pops a word on each handshake.
// -----------------------------------------------------------------------------
module tb_mat_result_drain;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;
  localparam int CW     = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  idx;
    logic        last;
  } word_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_r00 = '0, in_r01 = '0, in_r10 = '0, in_r11 = '0;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_idx;
  logic              out_last;
  logic              out_ready = 1'b0;
  logic [CW-1:0]     count;
  logic              overflow;

  mat_result_drain #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .in_valid  (in_valid),
    .in_r00    (in_r00),
    .in_r01    (in_r01),
    .in_r10    (in_r10),
    .in_r11    (in_r11),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_mis = 0;
  word_t sb[$];
  int    acc_n = 0;   // matrices admitted
  int    drn_n = 0;   // matrices whose last word was accepted
  bit    m_ovf = 1'b0;
  bit    seen_edge;
  int    max_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // in_ready only becomes meaningful after the first clock following reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) seen_edge <= 1'b0;
    else        seen_edge <= 1'b1;
  end

  // Monitor: compare on the falling edge, pop on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      int exp_cnt;
      exp_cnt = acc_n - drn_n;
      if (int'(count) > max_cnt) max_cnt = int'(count);
      check("count", 64'(count), 64'(exp_cnt));
      if (seen_edge) check("in_ready", 64'(in_ready), 64'(exp_cnt < DEPTH));
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
      if (!out_valid) check("idle_data", 64'(out_data), 64'd0);
      if (out_valid && sb.size() != 0) begin
        word_t exp_w;
        exp_w = sb[0];
        check("word{data,idx,last}", {29'd0, out_data, out_idx, out_last}, 64'(exp_w));
        if (out_ready) begin
          void'(sb.pop_front());
          if (exp_w.last) drn_n++;
        end
      end
    end
  end

  // Called just after a rising edge; the pulse is captured on the next edge.
  task automatic drive_matrix(input logic [31:0] a, b, c, d);
    bit acc;
    acc      = (acc_n - drn_n) < DEPTH;
    in_valid = 1'b1;
    in_r00 = a; in_r01 = b; in_r10 = c; in_r11 = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (acc) begin
      sb.push_back('{a, 2'd0, 1'b0});
      sb.push_back('{b, 2'd1, 1'b0});
      sb.push_back('{c, 2'd2, 1'b0});
      sb.push_back('{d, 2'd3, 1'b1});
      acc_n++;
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic clear_model();
    sb.delete();
    acc_n = 0;
    drn_n = 0;
    m_ovf = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state while held in reset.
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_count",     64'(count),     64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_overflow",  64'(overflow),  64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    do_reset();
    check("in_ready_after_rst", 64'(in_ready), 64'd1);

    // Single matrix with out_ready high: exact latency.
    out_ready = 1'b1;
    drive_matrix(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000);
    @(negedge clk);
    check("t1_valid_T+1", 64'(out_valid), 64'd1);
    check("t1_idx_T+1",   64'(out_idx),   64'd0);
    check("t1_cnt_T+1",   64'(count),     64'd1);
    repeat (3) @(negedge clk);
    check("t1_last_T+4",  64'(out_last),  64'd1);
    check("t1_data_T+4",  64'(out_data),  64'h4080_0000);
    @(negedge clk);
    check("t1_valid_T+5", 64'(out_valid), 64'd0);
    check("t1_cnt_T+5",   64'(count),     64'd0);
    cycles(2);

    // Backpressure while idx == 1 for three cycles.
    drive_matrix(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000);
    cycles(1);
    out_ready = 1'b0;
    cycles(3);
    check("t2_hold_data", 64'(out_data), 64'h4000_0000);
    check("t2_hold_idx",  64'(out_idx),  64'd1);
    out_ready = 1'b1;
    cycles(6);
    check("t2_drained", 64'(sb.size()), 64'd0);

    // Fill and overflow: A, B admitted, C dropped.
    out_ready = 1'b0;
    drive_matrix(32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003);
    drive_matrix(32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003);
    drive_matrix(32'hC000_0000, 32'hC000_0001, 32'hC000_0002, 32'hC000_0003);
    check("t3_count",    64'(count),    64'd2);
    check("t3_in_ready", 64'(in_ready), 64'd0);
    check("t3_overflow", 64'(overflow), 64'd1);
    out_ready = 1'b1;
    cycles(12);
    check("t3_drained", 64'(sb.size()), 64'd0);

    // Same-edge free at full: the new matrix is still dropped.
    do_reset();
    out_ready = 1'b0;
    drive_matrix(32'h1111_0000, 32'h1111_0001, 32'h1111_0002, 32'h1111_0003);
    drive_matrix(32'h2222_0000, 32'h2222_0001, 32'h2222_0002, 32'h2222_0003);
    out_ready = 1'b1;
    cycles(3);
    drive_matrix(32'h3333_0000, 32'h3333_0001, 32'h3333_0002, 32'h3333_0003);
    @(negedge clk);
    check("t4_count",    64'(count),    64'd1);
    check("t4_overflow", 64'(overflow), 64'd1);
    cycles(8);
    check("t4_drained", 64'(sb.size()), 64'd0);

    // Wrap-around: five matrices, one every four cycles.
    do_reset();
    max_cnt   = 0;
    out_ready = 1'b1;
    for (int m = 0; m < 5; m++) begin
      drive_matrix(32'h5000_0000 + 32'(m * 16), 32'h5000_0001 + 32'(m * 16),
                   32'h5000_0002 + 32'(m * 16), 32'h5000_0003 + 32'(m * 16));
      cycles(3);
    end
    cycles(4);
    check("t5_drained",  64'(sb.size()),     64'd0);
    check("t5_overflow", 64'(overflow),      64'd0);
    check("t5_max_cnt",  64'(max_cnt <= 1),  64'd1);

    // Asynchronous reset mid-stream at idx == 2.
    drive_matrix(32'h6000_0000, 32'h6000_0001, 32'h6000_0002, 32'h6000_0003);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("t6_idx_before", 64'(out_idx), 64'd2);
    rst_n = 1'b0;
    clear_model();
    #1;
    check("t6_valid_rst",    64'(out_valid), 64'd0);
    check("t6_count_rst",    64'(count),     64'd0);
    check("t6_overflow_rst", 64'(overflow),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive_matrix(32'h7000_0000, 32'h7000_0001, 32'h7000_0002, 32'h7000_0003);
    @(negedge clk);
    check("t6_new_idx",  64'(out_idx),  64'd0);
    check("t6_new_data", 64'(out_data), 64'h7000_0000);
    cycles(6);
    check("t6_drained", 64'(sb.size()), 64'd0);

    // Randomised traffic with random backpressure.
    fork
      begin
        repeat (600) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        repeat (80) begin
          drive_matrix($urandom, $urandom, $urandom, $urandom);
          cycles($urandom_range(0, 6));
        end
      end
    join
    out_ready = 1'b1;
    cycles(20);
    check("rand_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
